// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and response signals shared by the memory port arbiter.
// The arbiter connects as slave; requesters and memory model connect as master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              we0;
    logic [LINE_W-1:0] wdata0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              we1;
    logic [LINE_W-1:0] wdata1;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;

    logic              ready0;
    logic              ready1;
    logic [LINE_W-1:0] rdata0;
    logic [LINE_W-1:0] rdata1;
    logic              resp_sel;
    logic              busy;

    modport slave (
        input  req0, addr0, we0, wdata0,
        input  req1, addr1, we1, wdata1,
        input  mem_ready, mem_rdata,
        output mem_req, mem_addr, mem_we, mem_wdata,
        output ready0, ready1, rdata0, rdata1, resp_sel, busy
    );

    modport master (
        output req0, addr0, we0, wdata0,
        output req1, addr1, we1, wdata1,
        output mem_ready, mem_rdata,
        input  mem_req, mem_addr, mem_we, mem_wdata,
        input  ready0, ready1, rdata0, rdata1, resp_sel, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction cache (0)
// and the data cache (1); one transaction in flight, response demuxed by resp_sel.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   ptr;
    logic   grant_any;
    logic   grant_sel;

    // On a tie the pointer decides; otherwise the lone requester wins.
    always_comb begin
        grant_any = bus.req0 | bus.req1;
        grant_sel = bus.req1 & (~bus.req0 | ptr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= {LINE_W{1'b0}};
            bus.ready0    <= 1'b0;
            bus.ready1    <= 1'b0;
            bus.rdata0    <= {LINE_W{1'b0}};
            bus.rdata1    <= {LINE_W{1'b0}};
            bus.resp_sel  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        bus.resp_sel  <= grant_sel;
                        bus.mem_addr  <= grant_sel ? bus.addr1  : bus.addr0;
                        bus.mem_we    <= grant_sel ? bus.we1    : bus.we0;
                        bus.mem_wdata <= grant_sel ? bus.wdata1 : bus.wdata0;
                        bus.mem_req   <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // Requester inputs are deliberately not looked at here, so a dropped req cannot abort.
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        bus.rdata0  <= bus.resp_sel ? {LINE_W{1'b0}} : bus.mem_rdata;
                        bus.rdata1  <= bus.resp_sel ? bus.mem_rdata : {LINE_W{1'b0}};
                        bus.ready0  <= ~bus.resp_sel;
                        bus.ready1  <= bus.resp_sel;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    bus.ready0 <= 1'b0;
                    bus.ready1 <= 1'b0;
                    bus.rdata0 <= {LINE_W{1'b0}};
                    bus.rdata1 <= {LINE_W{1'b0}};
                    ptr        <= ~bus.resp_sel;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
